// File: rtl/lfsr_stream_cipher.sv
// LFSR keystream cipher over fixed-length frames of ASCII characters with a parity bit.
// Encrypt wraps a message in keystream pads; decrypt checks parity and strips the pads again.
module lfsr_stream_cipher #(
  parameter int unsigned LFSR_W    = 7,
  parameter int unsigned FRAME_LEN = 64,
  parameter int unsigned OFFSET    = 8'h20,
  parameter int unsigned DATA_W    = LFSR_W + 1,
  parameter int unsigned CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Mode,
  input  logic [LFSR_W-1:0] TapPtrn,
  input  logic [LFSR_W-1:0] LfsrInit,
  input  logic [CNT_W-1:0]  PreLen,
  input  logic [CNT_W-1:0]  MsgLen,
  input  logic [DATA_W-1:0] InData,
  input  logic              InValid,
  output logic              InReady,
  output logic [DATA_W-1:0] OutData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              Busy,
  output logic              Ack,
  output logic [CNT_W-1:0]  ErrCount
);

  typedef enum logic [2:0] {IDLE, PRE, MSG, POST, DONE} state_t;

  localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]  ERR_MAX   = '1;
  localparam logic [DATA_W-1:0] OFFSET_D  = DATA_W'(OFFSET);

  state_t              state, state_next;
  logic                start_q, mode_q;
  logic [LFSR_W-1:0]   taps_q, lfsr, lfsr_step, plain, cipher;
  logic [CNT_W-1:0]    pre_len_q, msg_end_q, cnt, cnt_next, pre_clip, msg_clip;
  logic [DATA_W-1:0]   out_char;
  logic                launch, active, need_in, room, fire, emit, out_valid_next, parity_err;

  // Frame region owning character index idx.
  function automatic state_t region(input logic [CNT_W-1:0] idx, input logic [CNT_W-1:0] pre,
                                    input logic [CNT_W-1:0] msg_end);
    if (idx < pre)          return PRE;
    else if (idx < msg_end) return MSG;
    else                    return POST;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    pre_clip       = (PreLen > FRAME_CNT) ? FRAME_CNT : PreLen;
    msg_clip       = (MsgLen > FRAME_CNT - pre_clip) ? FRAME_CNT - pre_clip : MsgLen;
    launch         = (state == IDLE) && start_q && !Start;
    active         = state inside {PRE, MSG, POST};
    need_in        = mode_q || (state == MSG);
    room           = !OutValid || OutReady;
    fire           = active && !Start && (cnt != FRAME_CNT) && room && (!need_in || InValid);
    emit           = fire && (!mode_q || (state == MSG));
    cnt_next       = fire ? cnt + CNT_W'(1) : cnt;
    out_valid_next = (active && Start) ? 1'b0 : (emit ? 1'b1 : (OutValid && !OutReady));
    lfsr_step      = {lfsr[LFSR_W-2:0], ^(lfsr & taps_q)};
    plain          = (state == MSG) ? LFSR_W'(InData - OFFSET_D) : '0;
    cipher         = plain ^ lfsr;
    out_char       = mode_q ? DATA_W'(InData[LFSR_W-1:0] ^ lfsr) + OFFSET_D : {^cipher, cipher};
    parity_err     = InData[DATA_W-1] != ^InData[LFSR_W-1:0];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: sequential state is written with non-blocking assignments only.
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // The frame only ends once the last character has left the output register.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (launch) state_next = region('0, pre_clip, pre_clip + msg_clip);
      PRE, MSG, POST: begin
        if (Start)                                       state_next = IDLE;
        else if (cnt_next == FRAME_CNT && !out_valid_next) state_next = DONE;
        else if (fire && cnt_next != FRAME_CNT)          state_next = region(cnt_next, pre_len_q, msg_end_q);
      end
      DONE: if (Start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Busy    = active;
    Ack     = (state == DONE);
    InReady = active && (cnt != FRAME_CNT) && need_in && room;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      start_q   <= 1'b0;
      mode_q    <= 1'b0;
      taps_q    <= '0;
      lfsr      <= '0;
      pre_len_q <= '0;
      msg_end_q <= '0;
      cnt       <= '0;
      OutData   <= '0;
      OutValid  <= 1'b0;
      ErrCount  <= '0;
    end else begin
      start_q  <= Start;
      OutValid <= out_valid_next;
      if (emit) OutData <= out_char;
      if (launch) begin
        mode_q    <= Mode;
        taps_q    <= TapPtrn;
        lfsr      <= (LfsrInit == '0) ? LFSR_W'(1) : LfsrInit;
        pre_len_q <= pre_clip;
        msg_end_q <= pre_clip + msg_clip;
        cnt       <= '0;
        ErrCount  <= '0;
      end else if (fire) begin
        lfsr <= lfsr_step;
        cnt  <= cnt_next;
        if (mode_q && parity_err && ErrCount != ERR_MAX) ErrCount <= ErrCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// Self-checking bench for lfsr_stream_cipher: known pad-only vectors, a frame-level reference
// model, backpressure, parity errors, clipping and mid-frame aborts.
module tb_lfsr_stream_cipher;
  localparam int CNT_W = 7;
  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic        mode;
    logic [6:0]  taps;
    logic [6:0]  seed;
    logic [7:0]  pre;
    logic [7:0]  msg;
    logic [31:0] exp_head;
    logic [7:0]  exp_ack;
  } vec_t;

  logic             Clk, Reset, Start, Mode, InValid, InReady, OutValid, OutReady, Busy, Ack;
  logic [6:0]       TapPtrn, LfsrInit;
  logic [CNT_W-1:0] PreLen, MsgLen, ErrCount;
  logic [7:0]       InData, OutData;

  int n_checks = 0;
  int n_pass   = 0;

  lfsr_stream_cipher dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode), .TapPtrn(TapPtrn), .LfsrInit(LfsrInit),
    .PreLen(PreLen), .MsgLen(MsgLen), .InData(InData), .InValid(InValid), .InReady(InReady),
    .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady), .Busy(Busy), .Ack(Ack),
    .ErrCount(ErrCount)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic cmp_frame(input string name, input byte_q_t got, input byte_q_t exp);
    int bad;
    bad = 0;
    check({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (got[i] !== exp[i]) bad++;
    check({name, "_bad_chars"}, bad, 0);
  endtask

  // Frame-level reference: keystream from the shift rule, pads are plaintext 0.
  task automatic model(input logic mode, input logic [6:0] taps, input logic [6:0] seed,
                       input int pre, input int msg, input byte_q_t in_q,
                       output byte_q_t exp_q, output int exp_err, output int exp_cons);
    int p, m, k;
    bit in_msg;
    logic [6:0] s, c;
    logic [7:0] d;
    p = (pre > 64) ? 64 : pre;
    m = (msg > 64 - p) ? 64 - p : msg;
    s = (seed == 0) ? 7'd1 : seed;
    k = 0; exp_q = {}; exp_err = 0;
    for (int i = 0; i < 64; i++) begin
      in_msg = (i >= p) && (i < p + m);
      if (!mode) begin
        c = 7'd0;
        if (in_msg) begin
          c = 7'(in_q[k] - 8'h20);
          k++;
        end
        c = c ^ s;
        exp_q.push_back({1'($countones(c) % 2), c});
      end else begin
        d = in_q[i];
        if (d[7] != 1'($countones(d[6:0]) % 2)) exp_err++;
        if (in_msg) exp_q.push_back(8'((int'(d[6:0] ^ s) + 32) % 256));
      end
      s = 7'((int'(s) * 2) % 128 + $countones(s & taps) % 2);
    end
    exp_cons = mode ? 64 : m;
  endtask

  // rdy_style: 0 always ready, 1 random, 2 five-cycle stall after 20 outputs.
  task automatic run_frame(input logic mode, input logic [6:0] taps, input logic [6:0] seed,
                           input int pre, input int msg, input byte_q_t in_q, input int rdy_style,
                           input bit vld_rand, input int stop_at, output byte_q_t got_q,
                           output int consumed, output int ack_cyc, output int viol);
    bit prev_stall, stall_done;
    logic [7:0] prev_data;
    int stall_left;
    got_q = {}; consumed = 0; ack_cyc = -1; viol = 0;
    prev_stall = 0; prev_data = '0; stall_left = 0; stall_done = 0;
    Mode = mode; TapPtrn = taps; LfsrInit = seed; PreLen = CNT_W'(pre); MsgLen = CNT_W'(msg);
    InValid = 1'b0; OutReady = 1'b1; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(posedge Clk); #1;
    Mode = ~mode; TapPtrn = 7'($urandom); LfsrInit = 7'($urandom);
    PreLen = CNT_W'($urandom); MsgLen = CNT_W'($urandom);
    for (int cyc = 0; cyc < 1000; cyc++) begin
      InValid = (consumed < in_q.size()) && (!vld_rand || $urandom_range(0, 2) != 0);
      InData  = InValid ? in_q[consumed] : 8'($urandom);
      if (rdy_style == 2 && !stall_done && got_q.size() == 20) begin
        stall_left = 5;
        stall_done = 1;
      end
      OutReady = (rdy_style == 1) ? ($urandom_range(0, 2) != 0) : (stall_left == 0);
      if (stall_left > 0) stall_left--;
      #2;
      if (Ack) begin
        if (Busy) viol++;
        ack_cyc = cyc;
        break;
      end
      if (!Busy) viol++;
      if (prev_stall && (!OutValid || OutData !== prev_data)) viol++;
      if (OutValid && !OutReady && InReady) viol++;
      if (stop_at >= 0 && got_q.size() == stop_at) break;
      if (InValid && InReady) consumed++;
      if (OutValid && OutReady) got_q.push_back(OutData);
      prev_stall = OutValid && !OutReady;
      prev_data  = OutData;
      @(posedge Clk); #1;
    end
  endtask

  task automatic full_check(input string name, input logic mode, input logic [6:0] taps,
                            input logic [6:0] seed, input int pre, input int msg,
                            input byte_q_t in_q, input int rdy_style, input bit vld_rand,
                            input int exp_ack, output byte_q_t got);
    byte_q_t exp_q;
    int exp_err, exp_cons, cons, ackc, viol;
    model(mode, taps, seed, pre, msg, in_q, exp_q, exp_err, exp_cons);
    run_frame(mode, taps, seed, pre, msg, in_q, rdy_style, vld_rand, -1, got, cons, ackc, viol);
    cmp_frame(name, got, exp_q);
    check({name, "_consumed"}, cons, exp_cons);
    check({name, "_errcount"}, ErrCount, exp_err);
    check({name, "_protocol_violations"}, viol, 0);
    if (exp_ack >= 0) check({name, "_ack_cycle"}, ackc, exp_ack);
    else              check({name, "_ack_seen"}, ackc >= 0, 1);
  endtask

  initial begin
    vec_t    vecs[5];
    byte_q_t msg_q, empty_q, ct_q, bad_q, got, rnd_q;
    string   msg_s;
    logic [31:0] head;
    logic [6:0]  seed;
    int quiet, pre, msg, exp_err, exp_cons, cons, ackc, viol;
    logic mode;

    vecs[0] = '{1'b0, 7'h60, 7'h01, 8'd10,  8'd0, 32'h81828488, 8'd65};
    vecs[1] = '{1'b0, 7'h60, 7'h00, 8'd10,  8'd0, 32'h81828488, 8'd65};
    vecs[2] = '{1'b0, 7'h60, 7'h03, 8'd64,  8'd0, 32'h03060C18, 8'd65};
    vecs[3] = '{1'b0, 7'h03, 7'h05, 8'd100, 8'd0, 32'h058B962D, 8'd65};
    vecs[4] = '{1'b0, 7'h60, 7'h7F, 8'd0,   8'd0, 32'hFF7EFC78, 8'd65};

    msg_s = " Knowledge comes, but wisdom lingers.    ";
    for (int i = 0; i < msg_s.len(); i++) msg_q.push_back(msg_s[i]);

    Reset = 1'b1; Start = 1'b0; Mode = 1'b0; TapPtrn = '0; LfsrInit = '0; PreLen = '0;
    MsgLen = '0; InData = '0; InValid = 1'b0; OutReady = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_outvalid", OutValid, 0);
    check("reset_busy", Busy, 0);
    check("reset_ack", Ack, 0);
    check("reset_inready", InReady, 0);
    check("reset_outdata", OutData, 0);
    check("reset_errcount", ErrCount, 0);
    Reset = 1'b0;
    quiet = 0;
    repeat (10) begin
      @(posedge Clk); #1;
      if (Busy || OutValid || Ack) quiet++;
    end
    check("start_low_no_launch", quiet, 0);

    foreach (vecs[v]) begin
      run_frame(vecs[v].mode, vecs[v].taps, vecs[v].seed, int'(vecs[v].pre), int'(vecs[v].msg),
                empty_q, 0, 0, -1, got, cons, ackc, viol);
      head = (got.size() >= 4) ? {got[0], got[1], got[2], got[3]} : 32'h0;
      check($sformatf("vec%0d_head", v), head, vecs[v].exp_head);
      check($sformatf("vec%0d_count", v), got.size(), 64);
      check($sformatf("vec%0d_ack_cycle", v), ackc, int'(vecs[v].exp_ack));
      check($sformatf("vec%0d_violations", v), viol, 0);
    end

    // Encrypt the reference sentence, then decrypt the model's ciphertext.
    seed = 7'($urandom_range(1, 127));
    rnd_q = msg_q;
    repeat (3) rnd_q.push_back(8'h41);
    full_check("enc_msg", 1'b0, 7'h60, seed, 10, 41, rnd_q, 0, 0, 65, got);
    model(1'b0, 7'h60, seed, 10, 41, rnd_q, ct_q, exp_err, exp_cons);
    ct_q.push_back(8'h00); ct_q.push_back(8'h00);
    full_check("dec_msg", 1'b1, 7'h60, seed, 10, 41, ct_q, 0, 0, 64, got);
    cmp_frame("dec_plaintext", got, msg_q);

    bad_q = ct_q; bad_q[20] = bad_q[20] ^ 8'h80;
    full_check("dec_flip20", 1'b1, 7'h60, seed, 10, 41, bad_q, 0, 0, 64, got);
    bad_q = ct_q; bad_q[5] = bad_q[5] ^ 8'h80;
    full_check("dec_flip5", 1'b1, 7'h60, seed, 10, 41, bad_q, 1, 1, -1, got);
    cmp_frame("dec_flip5_plaintext", got, msg_q);

    full_check("enc_stall", 1'b0, 7'h60, seed, 10, 41, rnd_q, 2, 0, 70, got);
    full_check("enc_clip", 1'b0, 7'h60, 7'h2B, 30, 60, {msg_q, msg_q}, 1, 1, -1, got);
    full_check("dec_fill", 1'b1, 7'h41, 7'h11, 20, 44, {ct_q, ct_q}, 0, 0, 65, got);

    for (int r = 0; r < 6; r++) begin
      mode = 1'($urandom); pre = $urandom_range(0, 70); msg = $urandom_range(0, 70);
      rnd_q = {};
      repeat (mode ? 66 : msg + 3) rnd_q.push_back(mode ? 8'($urandom) : 8'($urandom_range(32, 126)));
      full_check($sformatf("rand%0d", r), mode, 7'($urandom), 7'($urandom), pre, msg, rnd_q, 1, 1, -1, got);
    end

    // Reset pulse at character 30.
    rnd_q = msg_q;
    run_frame(1'b0, 7'h60, seed, 10, 41, rnd_q, 0, 0, 30, got, cons, ackc, viol);
    check("rst_abort_reached", got.size(), 30);
    Reset = 1'b1;
    #1;
    check("rst_abort_outvalid", OutValid, 0);
    check("rst_abort_busy_ack", {Busy, Ack}, 0);
    @(posedge Clk); #1;
    Reset = 1'b0; InValid = 1'b0;
    quiet = 0;
    repeat (8) begin
      @(posedge Clk); #1;
      if (Busy || OutValid || Ack) quiet++;
    end
    check("rst_abort_quiet", quiet, 0);
    full_check("rst_relaunch", 1'b0, 7'h60, seed, 10, 41, rnd_q, 0, 0, 65, got);

    // Start abort at character 30.
    run_frame(1'b0, 7'h60, seed, 10, 41, rnd_q, 0, 0, 30, got, cons, ackc, viol);
    Start = 1'b1;
    @(posedge Clk); #1;
    check("start_abort_outvalid", OutValid, 0);
    check("start_abort_busy_ack", {Busy, Ack}, 0);
    quiet = 0;
    repeat (4) begin
      @(posedge Clk); #1;
      if (Busy || OutValid || Ack) quiet++;
    end
    check("start_abort_quiet", quiet, 0);
    full_check("start_relaunch", 1'b0, 7'h60, seed, 10, 41, rnd_q, 0, 0, 65, got);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
